// File: rtl/ysyx_23060203_mdu.sv
// Iterative RV M-extension multiply/divide unit: shift-add multiply and restoring
// divide on operand magnitudes, ITER_BITS steps per cycle, with valid/ready handshakes.
module ysyx_23060203_mdu #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned ITER_BITS = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    output logic            in_ready,
    input  logic            in_valid,
    input  logic [2:0]      in_funct,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    input  logic            out_ready,
    output logic            out_valid,
    output logic [XLEN-1:0] out_res
);

    localparam int unsigned N     = XLEN / ITER_BITS;
    localparam int unsigned CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_funct;
    logic              r_neg;
    logic [XLEN-1:0]   r_res;
    logic [2*XLEN-1:0] r_prod;
    logic [2*XLEN-1:0] r_mcand;
    logic [XLEN-1:0]   r_mplier;
    logic [XLEN:0]     r_rem;
    logic [XLEN-1:0]   r_quo;
    logic [XLEN-1:0]   r_dsor;

    logic              w_accept;
    logic              w_sa;
    logic              w_sb;
    logic              w_neg;
    logic [XLEN-1:0]   w_abs_a;
    logic [XLEN-1:0]   w_abs_b;
    logic              w_div0;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_mcand;
    logic [XLEN-1:0]   w_mplier;
    logic [XLEN:0]     w_rem;
    logic [XLEN-1:0]   w_quo;
    logic [2*XLEN-1:0] w_prod_fin;
    logic [XLEN-1:0]   w_quo_fin;
    logic [XLEN-1:0]   w_rem_fin;
    logic [XLEN-1:0]   w_result;

    assign in_ready  = (r_state == IDLE) | ((r_state == DONE) & out_ready);
    assign w_accept  = in_valid & in_ready & ~flush;
    assign out_valid = (r_state == DONE) & ~flush;
    assign out_res   = r_res;

    // Operand signedness: rs1 is signed for mulh/mulhsu/div/rem, rs2 for mulh/div/rem.
    assign w_sa = in_a[XLEN-1] & ((in_funct == 3'b001) | (in_funct == 3'b010) |
                                  (in_funct == 3'b100) | (in_funct == 3'b110));
    assign w_sb = in_b[XLEN-1] & ((in_funct == 3'b001) | (in_funct == 3'b100) |
                                  (in_funct == 3'b110));
    assign w_abs_a = w_sa ? (~in_a + 1'b1) : in_a;
    assign w_abs_b = w_sb ? (~in_b + 1'b1) : in_b;
    assign w_neg   = (in_funct[2] & in_funct[1]) ? w_sa : (w_sa ^ w_sb);

    assign w_div0 = in_funct[2] & (in_b == '0);
    assign w_ovf  = in_funct[2] & ~in_funct[0] & (in_a == {1'b1, {(XLEN-1){1'b0}}}) &
                    (in_b == '1);
    assign w_special     = w_div0 | w_ovf;
    assign w_special_res = w_div0 ? (in_funct[1] ? in_a : '1) : (in_funct[1] ? '0 : in_a);

    always_comb begin
        w_prod   = r_prod;
        w_mcand  = r_mcand;
        w_mplier = r_mplier;
        w_rem    = r_rem;
        w_quo    = r_quo;
        for (int unsigned i = 0; i < ITER_BITS; i++) begin
            if (w_mplier[0]) begin
                w_prod = w_prod + w_mcand;
            end
            w_mcand  = w_mcand << 1;
            w_mplier = w_mplier >> 1;
            w_rem    = {w_rem[XLEN-1:0], w_quo[XLEN-1]};
            w_quo    = w_quo << 1;
            if (w_rem >= {1'b0, r_dsor}) begin
                w_rem    = w_rem - {1'b0, r_dsor};
                w_quo[0] = 1'b1;
            end
        end
    end

    assign w_prod_fin = r_neg ? (~w_prod + 1'b1) : w_prod;
    assign w_quo_fin  = r_neg ? (~w_quo + 1'b1) : w_quo;
    assign w_rem_fin  = r_neg ? (~w_rem[XLEN-1:0] + 1'b1) : w_rem[XLEN-1:0];

    always_comb begin
        w_result = w_prod_fin[XLEN-1:0];
        case (r_funct)
            3'b000:         w_result = w_prod_fin[XLEN-1:0];
            3'b001, 3'b010,
            3'b011:         w_result = w_prod_fin[2*XLEN-1:XLEN];
            3'b100, 3'b101: w_result = w_quo_fin;
            default:        w_result = w_rem_fin;
        endcase
    end

    // Accept is only possible from IDLE or a consumed DONE, so it is handled ahead of the state case.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_funct  <= '0;
            r_neg    <= 1'b0;
            r_res    <= '0;
            r_prod   <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dsor   <= '0;
        end else if (flush) begin
            r_state <= IDLE;
        end else if (w_accept) begin
            r_funct  <= in_funct;
            r_neg    <= w_neg;
            r_cnt    <= CNT_W'(N);
            r_prod   <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_abs_a};
            r_mplier <= w_abs_b;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_dsor   <= w_abs_b;
            if (w_special) begin
                r_res   <= w_special_res;
                r_state <= DONE;
            end else begin
                r_state <= CALC;
            end
        end else begin
            case (r_state)
                CALC: begin
                    r_prod   <= w_prod;
                    r_mcand  <= w_mcand;
                    r_mplier <= w_mplier;
                    r_rem    <= w_rem;
                    r_quo    <= w_quo;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_res   <= w_result;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ysyx_23060203_mdu.md
Name: ysyx_23060203_mdu

Overview:
- Parametrised iterative multiply/divide unit for the execute stage; implements all eight RV M-extension ops.
- Sits beside the LSU inside the execute stage, behind the same valid/ready handshake.
- The execute stage gates `in_valid` with its own accept condition and ORs `~in_ready` into its stall.
- Results return through a held output register; `flush` squashes in-flight work.

Parameters:
- XLEN, 32, operand/result width; must be even and ≥8.
- ITER_BITS, 1, quotient/multiplier bits processed per iteration; must divide XLEN; N = XLEN/ITER_BITS iterations.

Ports:
- clock  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- flush  in  1  squash in-flight/pending op, same cycle
- in_ready  out  1  unit can accept an op
- in_valid  in  1  op presented
- in_funct  in  3  RV funct3: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
- in_a  in  XLEN  rs1 operand
- in_b  in  XLEN  rs2 operand
- out_ready  in  1  consumer accepts result
- out_valid  out  1  result valid
- out_res  out  XLEN  result

Behaviour:
- **Reset (asynchronous, reset=0):**
  - state=IDLE, out_valid=0, out_res=0, iteration counter=0.
  - Reset asserted mid-operation aborts immediately; no result is ever produced.
- **States:** IDLE, CALC, DONE.
- **Handshakes:**
  - in_ready = (state==IDLE) | (state==DONE & out_ready).
  - Accept = in_valid & in_ready & ~flush; flush wins over a simultaneous in_valid (op dropped).
  - out_valid = (state==DONE) & ~flush, combinational gate.
  - Result is consumed on out_valid & out_ready.
- **Transitions:**
  - IDLE, accept, normal op → CALC. Operands are latched; the counter is loaded with N.
  - IDLE/DONE, accept, special case → DONE on the next edge (1-cycle latency). Special cases:
    - divide by zero;
    - signed overflow (div/rem with a = 1<<(XLEN-1), b = all-ones).
  - CALC: one iteration per cycle, counter decrements. When the counter reaches 1 at an edge, the result is registered and state → DONE.
  - Normal latency is N+1 edges from accept to out_valid high (XLEN=32, ITER_BITS=1: 33).
  - DONE & out_ready & ~accept → IDLE.
  - DONE & out_ready & accept → CALC (or DONE for a special case); back-to-back, no bubble.
  - DONE & ~out_ready: hold; out_res stable, no new accept.
  - flush in any state → IDLE on the next edge. The internal result is discarded, but out_res keeps its last value (don't-care while out_valid=0).
- **Arithmetic:**
  - Multiply: shift-add on magnitudes into a 2·XLEN product.
    - Sign handling: mulh signed×signed, mulhsu signed×unsigned, mulhu and mul unsigned.
    - Product is negated at the end when the signs differ.
    - mul returns product[XLEN-1:0]; mulh* return product[2XLEN-1:XLEN].
  - Divide: restoring, on magnitudes, ITER_BITS quotient bits per cycle.
    - Quotient sign = sign(a) XOR sign(b).
    - Remainder takes the sign of the dividend (truncating division).
  - Divide by zero: quotient = all-ones, remainder = a.
  - Signed overflow: quotient = a, remainder = 0.
- in_funct/in_a/in_b are sampled only on accept; their changes at other times are ignored.

Test Plan:
- **mul, XLEN=32, ITER_BITS=1:** a=7, b=0xFFFFFFFD, out_ready=1 → out_res=0xFFFFFFEB; out_valid exactly 33 cycles after accept, for 1 cycle; then IDLE.
- **High-half multiplies:**
  - mulh 0x80000000×0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- **Signed divide:**
  - div −7/2 → 0xFFFFFFFD.
  - rem −7/2 → 0xFFFFFFFF.
  - divu 100/7 → 14.
  - remu 100/7 → 2.
- **Special cases, all 1-cycle latency:**
  - divu 5/0 → 0xFFFFFFFF.
  - rem 5/0 → 5.
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
  - rem of the same → 0.
- **flush:**
  - flush at the 10th CALC cycle → out_valid never rises for that op; in_ready=1 next cycle; the following divu 9/3 → 3.
  - flush coincident with in_valid in IDLE → op not accepted.
- **Backpressure / reset / parameters:**
  - out_ready=0 for 5 cycles in DONE → out_valid held, out_res stable, in_ready=0. Then out_ready=1 with in_valid=1 → new op accepted the same cycle.
  - reset pulled low mid-CALC → out_valid=0 and out_res=0 immediately.
  - XLEN=64, ITER_BITS=2: mulhu 2^63×4 → 2, latency 33.
